vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Produces the VGA raster timing that drives all object renderers: the free-running HCount/VCount pixel counters, hsync/vsync, video_on and a pixel-rate enable.
- Also latches the display-mode controls (full_screen, shape select) once per frame, so renderers never see a mode change mid-frame.
- Sits between the board clock and the object/colour-mux blocks; every object block consumes its HCount/VCount.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- full_screen_in  in  1  requested full-screen mode
- select_in  in  1  requested shape select
- HCount  out  10  current pixel column
- VCount  out  10  current line
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high when (HCount,VCount) is in the visible area
- pixel_tick  out  1  one-clk pulse per pixel period
- frame_start  out  1  one-clk pulse after the raster wraps to (0,0)
- full_screen  out  1  frame-latched full_screen_in
- select  out  1  frame-latched select_in

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- All outputs are registered. Reset is asynchronous, active low, and sets:
  - HCount=H_TOTAL-1 (799), VCount=V_TOTAL-1 (524)
  - hsync=1, vsync=1, video_on=0
  - pixel_tick=0, frame_start=0, full_screen=0, select=0
  - divider=0
- Reset mid-frame aborts the frame immediately, with the same values.
- Divider:
  - counts 0..CLK_DIV-1 on every clk and wraps.
  - pixel_tick is high in the cycle where divider==CLK_DIV-1.
  - With CLK_DIV=1, pixel_tick is constantly 1 after reset release.
- Counters advance only at the clk edge ending a pixel_tick cycle:
  - HCount increments; at H_TOTAL-1 it wraps to 0.
  - VCount increments on an HCount wrap; at V_TOTAL-1 it wraps to 0.
- First tick after reset release therefore lands on (0,0), at rising edge number CLK_DIV after release. No visible pixel of the first frame is lost.
- Registered status signals, updated on the same edge as the counters and always consistent with the new counter values:
  - video_on = (HCount<H_DISPLAY)&&(VCount<V_DISPLAY)
  - hsync=0 iff H_DISPLAY+H_FRONT <= HCount <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751)
  - vsync=0 iff V_DISPLAY+V_FRONT <= VCount <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491), for the whole line including blanking
- Between ticks all of HCount, VCount, hsync, vsync and video_on hold their values.
- Frame wrap = the edge where (799,524) -> (0,0):
  - frame_start goes high for exactly one clk on that edge.
  - full_screen<=full_screen_in and select<=select_in on that same edge.
  - Input changes at any other time are ignored until the next wrap. A change coincident with the wrap edge is captured.
- Counter widths: 10 bits, never exceeding H_TOTAL-1 / V_TOTAL-1. Comparisons are unsigned.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks (840000 at defaults).

Test Plan:
- Reset and start-up: hold rst_n=0, then release.
  - During reset: HCount=799, VCount=524, hsync=vsync=1, video_on=0.
  - 2nd clk edge after release: (0,0), video_on=1, frame_start=1 for one clk.
- Horizontal timing, line 0:
  - video_on falls when HCount=640.
  - hsync falls at HCount=656 and rises at HCount=752: low for 96 ticks = 192 clks.
  - Line length is 800 ticks.
- Vertical timing:
  - vsync low exactly while VCount is 490 or 491.
  - video_on stays 0 for all of VCount 480..524.
  - Successive frame_start pulses are 840000 clks apart.
- Mode latching:
  - Set full_screen_in=1, select_in=1 at VCount=100.
  - Outputs stay 0 until the next wrap, then read 1.
  - Toggling the inputs back mid-frame leaves the outputs at 1 until the following wrap.
- Reset mid-frame: assert rst_n=0 at (300,200) with full_screen=1.
  - Outputs immediately (asynchronously) return to the reset values, with full_screen=0.
  - After release, the raster restarts at (0,0) on the 2nd edge.
- CLK_DIV=1 build:
  - pixel_tick stays 1.
  - HCount advances every clk.
  - Frame length is 420000 clks; hsync is low for 96 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, free-running HCount/VCount,
// registered sync/blanking status and once-per-frame latching of display-mode controls.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       full_screen_in,
  input  logic       select_in,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       full_screen,
  output logic       select
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] divider_r;
  logic [DIV_W-1:0] divider_next_s;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             frame_wrap_s;
  logic             video_on_next_s;
  logic             hsync_next_s;
  logic             vsync_next_s;

  // Next divider phase and next raster position; the raster steps on the last divider phase
  always_comb begin
    divider_next_s = divider_r;
    h_next_s       = HCount;
    v_next_s       = VCount;
    frame_wrap_s   = 1'b0;
    if (divider_r == DIV_LAST) begin
      divider_next_s = DIV_ZERO;
      if (HCount == H_LAST) begin
        h_next_s = 10'd0;
        if (VCount == V_LAST) begin
          v_next_s     = 10'd0;
          frame_wrap_s = 1'b1;
        end else begin
          v_next_s = VCount + 10'd1;
        end
      end else begin
        h_next_s = HCount + 10'd1;
      end
    end else begin
      divider_next_s = divider_r + DIV_ONE;
    end
  end

  // Status derived from the next position so it lands on the same edge as the counters
  always_comb begin
    video_on_next_s = (h_next_s < H_VIS) && (v_next_s < V_VIS);
    hsync_next_s    = !((h_next_s >= HS_FIRST) && (h_next_s <= HS_LAST));
    vsync_next_s    = !((v_next_s >= VS_FIRST) && (v_next_s <= VS_LAST));
  end

  // Raster state, status outputs and per-frame mode latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divider_r   <= DIV_ZERO;
      HCount      <= H_LAST;
      VCount      <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
      full_screen <= 1'b0;
      select      <= 1'b0;
    end else begin
      divider_r   <= divider_next_s;
      pixel_tick  <= (divider_next_s == DIV_LAST);
      HCount      <= h_next_s;
      VCount      <= v_next_s;
      hsync       <= hsync_next_s;
      vsync       <= vsync_next_s;
      video_on    <= video_on_next_s;
      frame_start <= frame_wrap_s;
      // Mode controls only change on the frame wrap so renderers see a stable frame
      if (frame_wrap_s) begin
        full_screen <= full_screen_in;
        select      <= select_in;
      end else begin
        full_screen <= full_screen;
        select      <= select;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default geometry for start-up and line timing, a shrunken raster
// (CLK_DIV=2 and CLK_DIV=1) for whole-frame, mode-latch and mid-frame reset behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, fs_in, sel_in;
  logic [9:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
  logic a_hs, a_vs, a_vo, a_pt, a_fs, a_full, a_sel;
  logic b_hs, b_vs, b_vo, b_pt, b_fs, b_full, b_sel;
  logic c_hs, c_vs, c_vo, c_pt, c_fs, c_full, c_sel;
  int checks = 0;
  int errors = 0;

  vga_sync_gen dut_a (
    .clk(clk), .rst_n(rst_n), .full_screen_in(fs_in), .select_in(sel_in),
    .HCount(a_hc), .VCount(a_vc), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
    .pixel_tick(a_pt), .frame_start(a_fs), .full_screen(a_full), .select(a_sel)
  );

  // 15 x 12 raster: hsync low at H 10..12, vsync low at V 8..9, visible 8 x 6
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .full_screen_in(fs_in), .select_in(sel_in),
    .HCount(b_hc), .VCount(b_vc), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
    .pixel_tick(b_pt), .frame_start(b_fs), .full_screen(b_full), .select(b_sel)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .CLK_DIV(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .full_screen_in(fs_in), .select_in(sel_in),
    .HCount(c_hc), .VCount(c_vc), .hsync(c_hs), .vsync(c_vs), .video_on(c_vo),
    .pixel_tick(c_pt), .frame_start(c_fs), .full_screen(c_full), .select(c_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_b_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (b_fs === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_b_pos(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ((b_vc == 10'(v)) && (h < 0 || b_hc == 10'(h))) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int t_vo, hc_vo, t_hf, hc_hf, t_hr, hc_hr, t_line, hc_line, hc_k1, vs_low;
    int bad_cnt, bad_st, bad_fs, bad_pt, c_hs_low, eh, ev;
    bit ok;

    rst_n = 1'b0; fs_in = 1'b0; sel_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_hc", a_hc, 799);
    chk("rst_a_vc", a_vc, 524);
    chk("rst_a_sync", {a_hs, a_vs, a_vo, a_pt, a_fs, a_full, a_sel}, 7'b1100000);
    chk("rst_b_pos", {b_hc, b_vc}, {10'd14, 10'd11});

    rst_n = 1'b1;
    @(negedge clk);
    chk("edge1_a_hc", a_hc, 799);
    chk("edge1_a_tick", a_pt, 1);
    chk("edge1_c_pos", {c_hc, c_vc, c_fs, c_pt}, {10'd0, 10'd0, 2'b11});
    @(negedge clk);
    chk("edge2_a_pos", {a_hc, a_vc}, 20'd0);
    chk("edge2_a_flags", {a_vo, a_fs, a_pt, a_hs, a_vs}, 5'b11011);
    chk("edge2_b_start", {b_hc, b_vc, b_fs}, 21'd1);
    chk("edge2_c_hc", {c_hc, c_fs}, {10'd1, 1'b0});

    // Line 0 of the full-size raster
    t_vo = -1; t_hf = -1; t_hr = -1; t_line = -1; vs_low = 0; hc_k1 = -1;
    hc_vo = 0; hc_hf = 0; hc_hr = 0; hc_line = 0;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (k == 1) hc_k1 = int'(a_hc);
      if (k == 1) chk("a_fs_one_clk", a_fs, 0);
      if (a_vs !== 1'b1) vs_low++;
      if (t_vo < 0 && a_vo === 1'b0) begin t_vo = k; hc_vo = int'(a_hc); end
      if (t_hf < 0 && a_hs === 1'b0) begin t_hf = k; hc_hf = int'(a_hc); end
      if (t_hf >= 0 && t_hr < 0 && a_hs === 1'b1) begin t_hr = k; hc_hr = int'(a_hc); end
      if (t_line < 0 && a_vc == 10'd1) begin t_line = k; hc_line = int'(a_hc); end
    end
    chk("a_hold_between_ticks", hc_k1, 0);
    chk("a_vo_fall_hc", hc_vo, 640);
    chk("a_vo_fall_clk", t_vo, 1280);
    chk("a_hs_fall_hc", hc_hf, 656);
    chk("a_hs_rise_hc", hc_hr, 752);
    chk("a_hs_low_clks", t_hr - t_hf, 192);
    chk("a_line_clks", t_line, 1600);
    chk("a_line_wrap_hc", hc_line, 0);
    chk("a_vs_line0", vs_low, 0);

    // One whole frame of the small CLK_DIV=2 raster against a position model
    wait_b_fs(ok);
    chk("b_fs_wait", ok, 1);
    bad_cnt = 0; bad_st = 0; bad_fs = 0;
    for (int k = 1; k <= 360; k++) begin
      @(negedge clk);
      eh = (k / 2) % 15;
      ev = ((k / 2) / 15) % 12;
      if (b_hc !== 10'(eh) || b_vc !== 10'(ev)) bad_cnt++;
      if (b_vo !== ((eh < 8) && (ev < 6))) bad_st++;
      if (b_hs !== !(eh >= 10 && eh <= 12)) bad_st++;
      if (b_vs !== !(ev == 8 || ev == 9)) bad_st++;
      if (b_fs !== (k == 360)) bad_fs++;
    end
    chk("b_frame_counters", bad_cnt, 0);
    chk("b_frame_status", bad_st, 0);
    chk("b_frame_start_360", bad_fs, 0);

    // One whole frame of the CLK_DIV=1 raster
    bad_cnt = 0; bad_st = 0; bad_fs = 0; bad_pt = 0; c_hs_low = 0;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (c_fs === 1'b1) ok = 1'b1;
    end
    chk("c_fs_wait", ok, 1);
    for (int k = 1; k <= 180; k++) begin
      @(negedge clk);
      eh = k % 15;
      ev = (k / 15) % 12;
      if (c_hc !== 10'(eh) || c_vc !== 10'(ev)) bad_cnt++;
      if (c_hs !== !(eh >= 10 && eh <= 12)) bad_st++;
      if (c_fs !== (k == 180)) bad_fs++;
      if (c_pt !== 1'b1) bad_pt++;
      if (c_hs === 1'b0 && k < 180) c_hs_low++;
    end
    chk("c_frame_counters", bad_cnt, 0);
    chk("c_hsync_model", bad_st, 0);
    chk("c_frame_start_180", bad_fs, 0);
    chk("c_tick_constant", bad_pt, 0);
    chk("c_hs_low_clks", c_hs_low, 36);

    // Mode latching on the small raster
    wait_b_pos(-1, 3, ok);
    chk("b_wait_v3", ok, 1);
    fs_in = 1'b1; sel_in = 1'b1;
    @(negedge clk);
    chk("b_mode_midframe", {b_full, b_sel}, 2'b00);
    wait_b_fs(ok);
    chk("b_mode_wrap1", {ok, b_full, b_sel}, 3'b111);
    wait_b_pos(-1, 3, ok);
    fs_in = 1'b0; sel_in = 1'b0;
    @(negedge clk);
    chk("b_mode_hold_after_clear", {ok, b_full, b_sel}, 3'b111);
    wait_b_pos(-1, 10, ok);
    chk("b_mode_hold_late", {ok, b_full, b_sel}, 3'b111);
    wait_b_fs(ok);
    chk("b_mode_wrap2", {ok, b_full, b_sel}, 3'b100);
    fs_in = 1'b1;
    wait_b_fs(ok);
    chk("b_mode_wrap3", {ok, b_full, b_sel}, 3'b110);
    chk("a_mode_no_wrap", {a_full, a_sel}, 2'b00);

    // Mid-frame asynchronous reset
    wait_b_pos(5, 4, ok);
    chk("b_wait_mid", ok, 1);
    rst_n = 1'b0;
    fs_in = 1'b0;
    #1;
    chk("mid_rst_b_pos", {b_hc, b_vc}, {10'd14, 10'd11});
    chk("mid_rst_b_flags", {b_hs, b_vs, b_vo, b_pt, b_fs, b_full, b_sel}, 7'b1100000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_edge1_b_hc", b_hc, 14);
    @(negedge clk);
    chk("mid_edge2_b", {b_hc, b_vc, b_fs, b_vo, b_full}, {20'd0, 3'b110});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
